// File: rtl/pulse_emitter.sv
// Glitch-free pulse-train generator: emits req_count pulses, each active and idle
// phase held HOLD cycles so a matching input stabilizer passes every phase.
module pulse_emitter #(
  parameter int unsigned HOLD_TIME_LOG = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter logic        IDLE_LEVEL    = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [CNT_WIDTH-1:0] req_count,
  output logic                 req_ready,
  output logic                 so,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned TW   = HOLD_TIME_LOG + 2;
  localparam int unsigned HOLD = (1 << HOLD_TIME_LOG) + 2;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_GAP,
    S_FIN
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   r_so;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_so_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;

  // Next state, phase timer and remaining-pulse bookkeeping
  always_comb begin
    w_next      = r_state;
    w_timer_nxt = r_timer;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_cnt_nxt   = req_count;
          w_timer_nxt = HOLD_LAST;
          w_next      = (req_count == '0) ? S_FIN : S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (r_timer == '0) begin
          w_timer_nxt = HOLD_LAST;
          w_next      = S_GAP;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_GAP: begin
        if (r_timer == '0) begin
          w_cnt_nxt   = r_cnt - CNT_WIDTH'(1);
          w_timer_nxt = HOLD_LAST;
          w_next      = (r_cnt == CNT_WIDTH'(1)) ? S_FIN : S_ACTIVE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_FIN: begin
        w_timer_nxt = '0;
        w_next      = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it
  always_comb begin
    w_so_nxt   = IDLE_LEVEL;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_next == S_ACTIVE) w_so_nxt = ~IDLE_LEVEL;
    if (w_next != S_IDLE)   w_busy_nxt = 1'b1;
    if (w_next == S_FIN)    w_done_nxt = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_cnt   <= '0;
      r_so    <= IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= w_timer_nxt;
      r_cnt   <= w_cnt_nxt;
      r_so    <= w_so_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign so        = r_so;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pulse_emitter.sv
// Scoreboard bench for pulse_emitter: the driver expands each accepted request into
// an expected per-cycle waveform; the monitor pops and compares it every cycle.
module tb_pulse_emitter;

  localparam int unsigned HTL  = 2;
  localparam int unsigned CW   = 4;
  localparam int          H    = (1 << HTL) + 2;
  localparam int          STAB = 1 << HTL;
  localparam logic        IDLE = 1'b0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [CW-1:0] req_count = '0;
  logic          req_ready;
  logic          so;
  logic          busy;
  logic          done;

  pulse_emitter #(
    .HOLD_TIME_LOG(HTL),
    .CNT_WIDTH    (CW),
    .IDLE_LEVEL   (IDLE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_count(req_count),
    .req_ready(req_ready),
    .so       (so),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic so;
    logic busy;
    logic done;
    logic ready;
    bit   first;
    int   n;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   cur_idle = 1'b1;

  // Loopback stabilizer model: output follows so once so has held STAB cycles
  int   stab_run = 0;
  logic stab_prev = IDLE;
  logic stab_out = IDLE;
  int   stab_rises = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: N pulses of H active + H idle cycles, then one done cycle
  task automatic push_train(input int n);
    exp_t e;
    for (int k = 0; k < 2 * n * H; k++) begin
      e.so    = ((k % (2 * H)) < H) ? ~IDLE : IDLE;
      e.busy  = 1'b1;
      e.done  = 1'b0;
      e.ready = 1'b0;
      e.first = (k == 0);
      e.n     = 0;
      q.push_back(e);
    end
    e.so    = IDLE;
    e.busy  = 1'b1;
    e.done  = 1'b1;
    e.ready = 1'b0;
    e.first = (n == 0);
    e.n     = n;
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        cur_idle = 1'b0;
      end else begin
        e = '{so: IDLE, busy: 1'b0, done: 1'b0, ready: 1'b1, first: 1'b0, n: 0};
        cur_idle = 1'b1;
      end
      if (e.first) stab_rises = 0;
      if (so === stab_prev) stab_run++;
      else stab_run = 1;
      stab_prev = so;
      if (stab_run >= STAB && so !== stab_out) begin
        if (so === ~IDLE) stab_rises++;
        stab_out = so;
      end
      chk("so", so, e.so);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("req_ready", req_ready, e.ready);
      if (e.done) begin
        chk_int("stab_pulses", stab_rises, e.n);
        chk("stab_level", stab_out, IDLE);
      end
    end
  end

  task automatic step(input logic r, input logic v, input int c);
    @(negedge clock);
    #1;
    reset     = r;
    req_valid = v;
    req_count = CW'(c);
    if (r) q.delete();
    else if (v && cur_idle) push_train(c);
  endtask

  task automatic drain();
    int g;
    g = 0;
    do begin
      step(1'b0, 1'b0, 0);
      g++;
    end while (!cur_idle && g < 2000);
    step(1'b0, 1'b0, 0);
  endtask

  initial begin
    @(posedge clock);
    #1 mon_en = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    step(1'b0, 1'b1, 3);
    drain();
    step(1'b0, 1'b1, 0);
    drain();
    step(1'b0, 1'b1, 15);
    drain();

    repeat (4 * (4 * H + 2)) step(1'b0, 1'b1, 2);
    drain();

    step(1'b0, 1'b1, 4);
    repeat (14) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1);
    drain();

    step(1'b0, 1'b1, 5);
    drain();

    repeat (1500) begin
      step(1'b0, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
